mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch requester and the data (load/store) requester of the 5-stage core.
- Sits between the IF/MEM stages and the memory, in place of the dual-read-port memory interface.
- Data accesses have priority over fetch. A streak counter prevents fetch starvation.
- Exports a busy flag so the stall logic can freeze the pipeline.

Parameters:
ADDR_WIDTH, 32, address width in bits (byte address)
DATA_WIDTH, 32, data width in bits
MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch is waiting (legal 1..15)
TIMEOUT_CYCLES, 255, cycles to wait for mem_ack before aborting (used only with ARB_TIMEOUT_EN; legal 2..255)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
inst_req  in  1  fetch request; held with inst_addr until inst_ack
inst_addr  in  ADDR_WIDTH  fetch byte address
inst_ack  out  1  one-cycle pulse: fetch complete, inst_rdata valid
inst_rdata  out  DATA_WIDTH  fetched word
data_req  in  1  data request; held with data_we/width/addr/wdata until data_ack
data_we  in  1  1 = store, 0 = load
data_width  in  4  byte count 1/2/4 (same encoding as the regfile write width)
data_addr  in  ADDR_WIDTH  data byte address
data_wdata  in  DATA_WIDTH  store data
data_ack  out  1  one-cycle pulse: data access complete, data_rdata valid for loads
data_rdata  out  DATA_WIDTH  load data
bus_err  out  1  pulses together with inst_ack/data_ack when the access timed out
busy  out  1  high whenever state != IDLE
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_width  out  4  memory write width
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_ack  in  1  memory completion pulse
mem_rdata  in  DATA_WIDTH  memory read data, valid when mem_ack=1

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State = IDLE, streak counter = 0, timeout counter = 0.
  - All outputs = 0, including mem_req, both acks, both rdata buses, bus_err and busy.
  - Reset during BUSY abandons the in-flight memory access; no ack is issued.
- All outputs are registered.
- FSM states: IDLE, BUSY_INST, BUSY_DATA, RESP.
- IDLE:
  - No request: stay in IDLE.
  - On an edge where a request is sampled, latch the winner's address, we, width and wdata into mem_* and set mem_req=1.
  - Next state is BUSY_INST or BUSY_DATA.
  - A fetch is issued as we=0, width=4.
- Arbitration when both requests are high:
  - Data wins unless streak == MAX_DATA_STREAK, in which case fetch wins.
  - Only one request high: it wins.
- Streak counter:
  - Increments on a data grant made while inst_req=1.
  - Clears on any fetch grant, or on a data grant made while inst_req=0.
  - Saturates at MAX_DATA_STREAK.
- BUSY_x:
  - mem_req and the latched mem_* fields stay stable until mem_ack is sampled high.
  - On the edge where mem_ack=1: mem_req goes to 0, x_rdata <= mem_rdata, x_ack <= 1, next state = RESP.
- RESP:
  - Exactly one ack is high, for exactly one cycle. Requests are ignored in this cycle.
  - Next state is IDLE; acks and bus_err return to 0.
- Requester rule: a requester that keeps req high in the cycle after its ack issues a new access.
- Minimum latency, request sampled at edge T0:
  - mem_req high after T0.
  - If mem_ack is high in the first cycle, ack is high after T0+1.
  - IDLE after T0+2.
  - Peak throughput is one access per 3 cycles.
- rdata retention: x_rdata holds its last value until the next ack to that requester. data_rdata is also updated on stores, with the value undefined by memory.
- No checking: data_width values other than 1/2/4 are forwarded unchanged. A mem_ack arriving outside BUSY is ignored.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined:
  - A timeout counter clears on entry to BUSY_x and increments every BUSY cycle without mem_ack.
  - When it reaches TIMEOUT_CYCLES: mem_req goes to 0, x_rdata = 0, x_ack = 1 and bus_err = 1 for the RESP cycle, then IDLE.
  - If mem_ack=1 on the same edge the limit is reached, the normal completion wins and bus_err = 0.
- Undefined: no counter exists, bus_err is tied to 0, and BUSY waits indefinitely for mem_ack.

Test Plan:
- Single fetch: inst_req=1, inst_addr=0x100, mem_ack in the first BUSY cycle with mem_rdata=0x00000013 -> mem_req high 1 cycle, mem_addr=0x100, mem_we=0, mem_width=4; inst_ack pulses 1 cycle with inst_rdata=0x00000013; busy falls one cycle later.
- Store: data_req=1, data_we=1, data_width=2, data_addr=0x2004, data_wdata=0xBEEF; mem_ack delayed 3 cycles -> mem_* fields stable for all 3 cycles; data_ack pulses once; inst_ack stays 0.
- Starvation guard (MAX_DATA_STREAK=4): inst_req and data_req held high continuously -> grant order D,D,D,D,I,D,D,D,D,I; streak returns to 0 after each fetch grant.
- Async reset asserted mid-BUSY_DATA, between clock edges -> mem_req, busy and data_ack drop to 0 immediately without waiting for clk; after release with no requests, state stays IDLE and no ack appears.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: load with mem_ack never asserted -> mem_req drops after 8 BUSY cycles; data_ack=1, bus_err=1, data_rdata=0 for one cycle. Repeat with mem_ack arriving on cycle 8 -> bus_err=0 and data_rdata=mem_rdata.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Define ARB_TIMEOUT_EN to abort accesses that see no mem_ack within TIMEOUT_CYCLES.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inst_req,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic                  inst_ack,
  output logic [DATA_WIDTH-1:0] inst_rdata,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [3:0]            data_width,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_ack,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  bus_err,
  output logic                  busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [3:0]            mem_width,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StBusyInst, StBusyData, StResp} state_e;

  localparam logic [3:0] MaxStreak = 4'(MAX_DATA_STREAK);

  state_e                state_q, state_d;
  logic [3:0]            streak_q, streak_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [3:0]            mem_width_q, mem_width_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  inst_ack_q, inst_ack_d;
  logic [DATA_WIDTH-1:0] inst_rdata_q, inst_rdata_d;
  logic                  data_ack_q, data_ack_d;
  logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;
  logic                  bus_err_q, bus_err_d;
  logic                  busy_q, busy_d;
  logic                  grant_data;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_q, tmo_d;
`endif

  // Fetch only wins a contested cycle once data has used up its streak.
  assign grant_data = data_req && !(inst_req && (streak_q == MaxStreak));

  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_width_d  = mem_width_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_ack_d   = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_ack_d   = 1'b0;
    data_rdata_d = data_rdata_q;
    bus_err_d    = 1'b0;
`ifdef ARB_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (data_req || inst_req) begin
          mem_req_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          tmo_d     = '0;
`endif
          if (grant_data) begin
            mem_we_d    = data_we;
            mem_width_d = data_width;
            mem_addr_d  = data_addr;
            mem_wdata_d = data_wdata;
            state_d     = StBusyData;
            if (!inst_req) begin
              streak_d = '0;
            end else if (streak_q != MaxStreak) begin
              streak_d = streak_q + 4'd1;
            end
          end else begin
            mem_we_d    = 1'b0;
            mem_width_d = 4'd4;
            mem_addr_d  = inst_addr;
            streak_d    = '0;
            state_d     = StBusyInst;
          end
        end
      end
      StBusyInst, StBusyData: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = StResp;
          if (state_q == StBusyInst) begin
            inst_ack_d   = 1'b1;
            inst_rdata_d = mem_rdata;
          end else begin
            data_ack_d   = 1'b1;
            data_rdata_d = mem_rdata;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (tmo_q == TmoLast) begin
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = StResp;
          if (state_q == StBusyInst) begin
            inst_ack_d   = 1'b1;
            inst_rdata_d = '0;
          end else begin
            data_ack_d   = 1'b1;
            data_rdata_d = '0;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      streak_q     <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_width_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      inst_ack_q   <= 1'b0;
      inst_rdata_q <= '0;
      data_ack_q   <= 1'b0;
      data_rdata_q <= '0;
      bus_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_width_q  <= mem_width_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_ack_q   <= inst_ack_d;
      inst_rdata_q <= inst_rdata_d;
      data_ack_q   <= data_ack_d;
      data_rdata_q <= data_rdata_d;
      bus_err_q    <= bus_err_d;
      busy_q       <= busy_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_width  = mem_width_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign inst_ack   = inst_ack_q;
  assign inst_rdata = inst_rdata_q;
  assign data_ack   = data_ack_q;
  assign data_rdata = data_rdata_q;
  assign bus_err    = bus_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (timeout steps only when
// ARB_TIMEOUT_EN is defined, with TIMEOUT_CYCLES = 8).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_width;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic        bus_err;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_width;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .MAX_DATA_STREAK(4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .inst_req  (inst_req),
    .inst_addr (inst_addr),
    .inst_ack  (inst_ack),
    .inst_rdata(inst_rdata),
    .data_req  (data_req),
    .data_we   (data_we),
    .data_width(data_width),
    .data_addr (data_addr),
    .data_wdata(data_wdata),
    .data_ack  (data_ack),
    .data_rdata(data_rdata),
    .bus_err   (bus_err),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_width (mem_width),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] order;
    reset      = 1'b1;
    inst_req   = 1'b0;
    inst_addr  = '0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_width = '0;
    data_addr  = '0;
    data_wdata = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;

    tick();
    tick();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_acks", {30'd0, inst_ack, data_ack}, 32'd0);
    check("rst_rdata", inst_rdata | data_rdata, 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    reset = 1'b0;
    tick();

    // Single fetch, memory answers in the first busy cycle.
    inst_req  = 1'b1;
    inst_addr = 32'h100;
    tick();
    check("f_mem_req", 32'(mem_req), 32'd1);
    check("f_mem_addr", mem_addr, 32'h100);
    check("f_mem_we", 32'(mem_we), 32'd0);
    check("f_mem_width", 32'(mem_width), 32'd4);
    check("f_busy", 32'(busy), 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0013;
    tick();
    inst_req = 1'b0;
    mem_ack  = 1'b0;
    check("f_mem_req_drop", 32'(mem_req), 32'd0);
    check("f_inst_ack", 32'(inst_ack), 32'd1);
    check("f_inst_rdata", inst_rdata, 32'h13);
    check("f_data_ack", 32'(data_ack), 32'd0);
    check("f_bus_err", 32'(bus_err), 32'd0);
    check("f_busy_resp", 32'(busy), 32'd1);
    tick();
    check("f_inst_ack_end", 32'(inst_ack), 32'd0);
    check("f_busy_end", 32'(busy), 32'd0);
    tick();
    check("f_idle_mem_req", 32'(mem_req), 32'd0);

    // Store with a three-cycle memory delay.
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_width = 4'd2;
    data_addr  = 32'h2004;
    data_wdata = 32'hBEEF;
    tick();
    check("s_mem_req", 32'(mem_req), 32'd1);
    check("s_mem_we", 32'(mem_we), 32'd1);
    check("s_mem_width", 32'(mem_width), 32'd2);
    check("s_mem_addr", mem_addr, 32'h2004);
    check("s_mem_wdata", mem_wdata, 32'hBEEF);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s_hold_req", 32'(mem_req), 32'd1);
      check("s_hold_addr", mem_addr, 32'h2004);
      check("s_hold_wdata", mem_wdata, 32'hBEEF);
      check("s_hold_width", 32'(mem_width), 32'd2);
      check("s_no_ack", 32'(data_ack), 32'd0);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_0001;
    tick();
    data_req = 1'b0;
    mem_ack  = 1'b0;
    check("s_data_ack", 32'(data_ack), 32'd1);
    check("s_inst_ack", 32'(inst_ack), 32'd0);
    check("s_mem_req_drop", 32'(mem_req), 32'd0);
    check("s_data_rdata", data_rdata, 32'hCAFE_0001);
    tick();
    check("s_ack_end", 32'(data_ack), 32'd0);
    check("s_busy_end", 32'(busy), 32'd0);
    check("s_inst_rdata_kept", inst_rdata, 32'h13);

    // Both requesters saturated, memory always ready.
    order      = 10'b11110_11110;
    data_we    = 1'b0;
    data_width = 4'd4;
    data_addr  = 32'h3000;
    inst_addr  = 32'h200;
    inst_req   = 1'b1;
    data_req   = 1'b1;
    mem_ack    = 1'b1;
    mem_rdata  = 32'h77;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("arb_mem_req", 32'(mem_req), 32'd1);
      check("arb_grant_addr", mem_addr, order[9-i] ? 32'h3000 : 32'h200);
      tick();
      check("arb_ack", {30'd0, inst_ack, data_ack}, order[9-i] ? 32'd1 : 32'd2);
      if (i == 9) begin
        inst_req = 1'b0;
        data_req = 1'b0;
      end
      tick();
      tick();
    end
    check("arb_idle_busy", 32'(busy), 32'd0);
    check("arb_idle_req", 32'(mem_req), 32'd0);
    mem_ack = 1'b0;

    // Asynchronous reset while a load is outstanding.
    data_req  = 1'b1;
    data_addr = 32'h40;
    tick();
    check("r_busy_before", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("r_mem_req_async", 32'(mem_req), 32'd0);
    check("r_busy_async", 32'(busy), 32'd0);
    check("r_data_ack_async", 32'(data_ack), 32'd0);
    check("r_data_rdata_async", data_rdata, 32'd0);
    data_req = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r_post_busy", 32'(busy), 32'd0);
      check("r_post_acks", {30'd0, inst_ack, data_ack}, 32'd0);
      check("r_post_req", 32'(mem_req), 32'd0);
    end

`ifdef ARB_TIMEOUT_EN
    // Ack arriving on the limit edge completes normally.
    data_req  = 1'b1;
    data_addr = 32'h80;
    mem_rdata = 32'h1234_5678;
    tick();
    for (int i = 1; i < 8; i++) begin
      tick();
      check("t1_wait_req", 32'(mem_req), 32'd1);
      check("t1_wait_ack", 32'(data_ack), 32'd0);
    end
    mem_ack = 1'b1;
    tick();
    data_req = 1'b0;
    mem_ack  = 1'b0;
    check("t1_data_ack", 32'(data_ack), 32'd1);
    check("t1_bus_err", 32'(bus_err), 32'd0);
    check("t1_rdata", data_rdata, 32'h1234_5678);
    tick();
    tick();

    // No ack at all: abort after eight busy cycles.
    data_req = 1'b1;
    tick();
    for (int i = 1; i < 8; i++) begin
      tick();
      check("t2_wait_req", 32'(mem_req), 32'd1);
      check("t2_wait_ack", 32'(data_ack), 32'd0);
    end
    tick();
    data_req = 1'b0;
    check("t2_mem_req_drop", 32'(mem_req), 32'd0);
    check("t2_data_ack", 32'(data_ack), 32'd1);
    check("t2_bus_err", 32'(bus_err), 32'd1);
    check("t2_rdata", data_rdata, 32'd0);
    tick();
    check("t2_ack_end", 32'(data_ack), 32'd0);
    check("t2_err_end", 32'(bus_err), 32'd0);
    check("t2_busy_end", 32'(busy), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
